// File: rtl/divider_meter_pkg.sv
// divider_meter_pkg: shared state encoding and default width for the period meter
package divider_meter_pkg;
    typedef enum logic [1:0] {IDLE, ARM, MEASURE} meter_state_e;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: two-flop synchroniser with registered rising-edge pulse
module sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic sig_in,
    output logic pulse
);
    logic s1, s2, s3;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) {s1, s2, s3, pulse} <= '0;
        else      {s1, s2, s3, pulse} <= {sig_in, s1, s2, s2 & ~s3};
    end
endmodule

// File: rtl/divider_period_meter.sv
// divider_period_meter: measures the period of a pulse train in clk cycles, with lock and overflow flags
module divider_period_meter
    import divider_meter_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int LOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             overflow,
    output logic             busy
);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       MATCH_TOP = 4'(LOCK_CNT - 1);

    meter_state_e     state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       match_cnt, match_nx;
    logic             have_prev, pulse, arm_hit, meas_done, ovf_hit;

    sync_edge_detect u_sync (.clk(clk), .rst(rst), .sig_in(sig_in), .pulse(pulse));

    // start overrides any edge or saturation seen in the same cycle
    assign arm_hit   = state == ARM && pulse && !start;
    assign meas_done = state == MEASURE && pulse && !start;
    assign ovf_hit   = state == MEASURE && !pulse && !start && cnt == CNT_MAX;
    assign match_nx  = (have_prev && cnt == period) ? (match_cnt == MATCH_TOP ? match_cnt : match_cnt + 4'd1) : 4'd0;
    assign busy      = state != IDLE;

    always_comb begin
        state_nx = state;
        state_nx = start ? ARM : arm_hit ? MEASURE : ovf_hit ? IDLE : state;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            match_cnt    <= '0;
            have_prev    <= 1'b0;
            locked       <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            period_valid <= meas_done;
            if (start) begin
                cnt       <= '0;
                match_cnt <= '0;
                have_prev <= 1'b0;
                locked    <= 1'b0;
                overflow  <= 1'b0;
            end else if (arm_hit) begin
                cnt <= CNT_W'(1);
            end else if (meas_done) begin
                period    <= cnt;
                cnt       <= CNT_W'(1);
                match_cnt <= match_nx;
                have_prev <= 1'b1;
                locked    <= match_nx == MATCH_TOP;
            end else if (ovf_hit) begin
                overflow <= 1'b1;
                locked   <= 1'b0;
            end else if (state == MEASURE) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_divider_period_meter.sv
// tb_divider_period_meter: two meter widths driven in lockstep against a time-stamp reference model
module tb_divider_period_meter;
    logic        clk = 1'b0;
    logic        rst, start, sig_in;
    logic [15:0] period_w;
    logic [3:0]  period_n;
    logic        valid_w, locked_w, ovf_w, busy_w;
    logic        valid_n, locked_n, ovf_n, busy_n;

    int errors = 0, checks = 0;
    int cyc = 0, floor_cyc = 0;
    bit samp [int];

    // model: 0 idle, 1 armed, 2 measuring; m_last is the cycle of the last accepted edge
    int m_mode [2], m_last [2], m_run [2], m_period [2], m_max [2];
    bit m_valid [2], m_locked [2], m_ovf [2];

    always #5 clk = ~clk;

    divider_period_meter #(.CNT_W(16), .LOCK_CNT(2)) dut_w (
        .clk(clk), .rst(rst), .start(start), .sig_in(sig_in), .period(period_w),
        .period_valid(valid_w), .locked(locked_w), .overflow(ovf_w), .busy(busy_w));

    divider_period_meter #(.CNT_W(4), .LOCK_CNT(2)) dut_n (
        .clk(clk), .rst(rst), .start(start), .sig_in(sig_in), .period(period_n),
        .period_valid(valid_n), .locked(locked_n), .overflow(ovf_n), .busy(busy_n));

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d cyc=%0d", tag, got, exp, cyc);
        end
    endtask

    task automatic check_outs();
        check("w_valid",  int'(valid_w),  int'(m_valid[0]));
        check("w_period", int'(period_w), m_period[0]);
        check("w_locked", int'(locked_w), int'(m_locked[0]));
        check("w_ovf",    int'(ovf_w),    int'(m_ovf[0]));
        check("w_busy",   int'(busy_w),   int'(m_mode[0] != 0));
        check("n_valid",  int'(valid_n),  int'(m_valid[1]));
        check("n_period", int'(period_n), m_period[1]);
        check("n_locked", int'(locked_n), int'(m_locked[1]));
        check("n_ovf",    int'(ovf_n),    int'(m_ovf[1]));
        check("n_busy",   int'(busy_n),   int'(m_mode[1] != 0));
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_last[d] = 0; m_run[d] = 0; m_period[d] = 0;
            m_valid[d] = 0; m_locked[d] = 0; m_ovf[d] = 0;
        end
    endtask

    task automatic model_step(input int d, input bit st, input bit e);
        int p;
        m_valid[d] = 0;
        if (st) begin
            m_mode[d] = 1; m_run[d] = 0; m_locked[d] = 0; m_ovf[d] = 0;
        end else if (m_mode[d] == 1 && e) begin
            m_mode[d] = 2; m_last[d] = cyc;
        end else if (m_mode[d] == 2 && e) begin
            p = cyc - m_last[d];
            m_run[d] = (m_run[d] > 0 && p == m_period[d]) ? m_run[d] + 1 : 1;
            m_period[d] = p;
            m_valid[d] = 1;
            m_locked[d] = m_run[d] >= 2;
            m_last[d] = cyc;
        end else if (m_mode[d] == 2 && cyc - m_last[d] == m_max[d]) begin
            m_mode[d] = 0; m_ovf[d] = 1; m_locked[d] = 0;
        end
    endtask

    // a rising sample taken at edge k is acted on by the FSM at edge k+3
    task automatic tick(input logic s, input logic st);
        int k;
        bit e;
        sig_in = s;
        start  = st;
        @(posedge clk);
        cyc++;
        samp[cyc] = rst ? s : 1'b0;
        if (!rst) floor_cyc = cyc;
        k = cyc - 3;
        e = (k > floor_cyc) && samp[k] && !samp[k-1];
        if (!rst) model_reset();
        else for (int d = 0; d < 2; d++) model_step(d, st, e);
        #1;
        check_outs();
    endtask

    task automatic train(input int p, input int w, input int n, input int chance);
        for (int i = 0; i < n; i++)
            for (int c = 0; c < p; c++)
                tick(c < w, chance > 0 && $urandom_range(chance - 1) == 0);
    endtask

    initial begin
        m_max[0] = 65535;
        m_max[1] = 15;
        samp[0] = 1'b0;
        rst = 1'b0; start = 1'b0; sig_in = 1'b0;
        model_reset();
        #1;
        check_outs();
        tick(0, 0); tick(0, 0);
        rst = 1'b1;
        tick(0, 1);
        train(8, 1, 4, 0);
        train(12, 1, 3, 0);
        repeat (20) tick(0, 0);
        tick(0, 1);
        train(15, 1, 3, 0);
        train(16, 1, 2, 0);
        tick(0, 1);
        train(2, 1, 4, 0);
        tick(0, 1);
        train(9, 1, 1, 0);
        repeat (5) tick(0, 0);
        #3 rst = 1'b0;
        floor_cyc = cyc;
        samp[cyc] = 1'b0;
        model_reset();
        #1;
        check_outs();
        tick(1, 0); tick(0, 0);
        rst = 1'b1;
        tick(0, 1);
        train(8, 1, 3, 0);
        train(8, 1, 2, 0);
        tick(0, 1);
        train(8, 1, 3, 0);
        tick(0, 1);
        train(8, 4, 4, 0);
        tick(1, 1);
        repeat (25) tick(1, 0);
        for (int s = 0; s < 40; s++) begin
            int p = $urandom_range(20, 2);
            tick(0, m_mode[0] == 0 || m_mode[1] == 0 || $urandom_range(1) == 1);
            train(p, $urandom_range(p - 1, 1), $urandom_range(5, 2), 60);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/divider_period_meter.md
Name: divider_period_meter

Overview:
Receive-side counterpart of the programmable frequency divider. It takes the divider's output pulse train (co) and measures its period in clk cycles, reporting each period with a one-cycle valid strobe. It also flags lock when consecutive periods are identical, and flags overflow when no edge arrives within the counter range. It sits beside the divider for self-check and for closed-loop use.

Parameters:
CNT_W, 16, width of the period counter and of the period output
LOCK_CNT, 2, number of consecutive identical measurements required to assert locked (range 2..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  one-cycle pulse; arms a new measurement run
sig_in  in  1  divided pulse train; asynchronous to logic, synchronised internally
period  out  CNT_W  last measured period in clk cycles
period_valid  out  1  one-cycle strobe; period updated this cycle
locked  out  1  LOCK_CNT consecutive equal periods seen
overflow  out  1  sticky; counter saturated with no edge
busy  out  1  high in ARM or MEASURE

Behaviour:
- Reset (rst=0, async): all outputs 0, state IDLE, counter 0, match count 0, sync flops 0.
- Input path: 2-flop synchroniser s1->s2, plus history flop s3. edge = s2 & ~s3.
- FSM states: IDLE, ARM, MEASURE.
- IDLE -> ARM on start. busy=0 in IDLE. overflow is cleared on start.
- ARM: wait for edge. On edge go to MEASURE, load cnt=1. No period_valid is produced for this first edge.
- MEASURE: cnt increments by 1 each cycle. On edge: period<=cnt, period_valid=1 for one cycle, cnt<=1.
  - Edges at detected cycles t and t+P give period=P.
- Latency: period_valid rises on the 3rd clk rising edge after the edge that first samples sig_in=1.
- Overflow: in MEASURE, cnt at all-ones with no edge -> overflow<=1, locked<=0, state->IDLE. period holds its last value.
- Lock: match_cnt is updated only on period_valid cycles.
  - If new period equals the previous period, match_cnt increments, saturating at LOCK_CNT-1. Otherwise match_cnt<=0.
  - locked = (match_cnt == LOCK_CNT-1), registered and updated in the same cycle as period_valid.
  - The first measurement after ARM always sets match_cnt=0.
- start in ARM or MEASURE: restart to ARM, clear cnt, match_cnt and locked. period is kept.
- start and edge in the same cycle: start wins; the edge is ignored.
- Edge in the same cycle cnt reaches all-ones: the edge wins. period=all-ones is valid and no overflow is raised.
- Minimum measurable period is 2 (pulse width ≥1 cycle, low ≥1 cycle). A constant-high sig_in produces no edges and eventually overflow.
- rst asserted mid-run: immediate return to the reset state; the in-flight measurement is discarded.

Decomposition:
- Package divider_meter_pkg: state enum typedef (IDLE, ARM, MEASURE) and a default CNT_W constant.
- One sub-module, sync_edge_detect: 2-flop synchroniser plus rising-edge pulse. Same clk/rst convention (async active-low).

Test Plan:
1. Reset, start, then sig_in high 1 clk every 8 clk (CNT_W=16, LOCK_CNT=2) -> no valid on 1st edge; period=8 with valid on 2nd edge; locked=1 on 3rd edge.
2. After lock, switch to period 12 -> next valid shows period=12 and locked=0; following valid shows 12 and locked=1.
3. CNT_W=4, start, one edge then sig_in held low -> overflow=1 when cnt=15 with no edge; busy=0; locked=0; period unchanged.
4. Drive rst=0 mid-MEASURE (after 5 counts) -> all outputs 0 immediately (asynchronous). After release and start, the first edge produces no valid.
5. start pulsed during MEASURE with locked=1 -> locked=0 and state ARM. The next edge produces no valid; the edge after that reports the correct period.
6. Drive sig_in from a 50%-duty divider output with toggle every 4 clk -> period=8 repeatedly; locked=1 after the 2nd valid.
